// File: rtl/scoot_pkg.sv
// Shared types and constants for the scoot grid-world environment stage.
package scoot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index of each direction inside a packed {left, down, right, up} vector
    localparam int UP    = 0;
    localparam int RIGHT = 1;
    localparam int DOWN  = 2;
    localparam int LEFT  = 3;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_HEIGHT    = 10;
    localparam int DEF_NUM_STEPS = 100;

endpackage

// File: rtl/scoot_world_if.sv
// Robot link: motor commands flow from the robot, light-sensor bits flow back to it.
interface scoot_world_if;

    logic mUp;
    logic mRight;
    logic mDown;
    logic mLeft;
    logic lUp;
    logic lRight;
    logic lDown;
    logic lLeft;

    modport master (
        output mUp, mRight, mDown, mLeft,
        input  lUp, lRight, lDown, lLeft
    );

    modport slave (
        input  mUp, mRight, mDown, mLeft,
        output lUp, lRight, lDown, lLeft
    );

endinterface

// File: rtl/scoot_wrap_step.sv
// Combinational +1 / -1 / 0 step on a value modulo N; opposing requests cancel.
module scoot_wrap_step #(
    parameter int N = 10
) (
    input  logic [$clog2(N)-1:0] val_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [$clog2(N)-1:0] res_o
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] MAX = W'(N - 1);

    always_comb begin
        res_o = val_i;
        if (inc_i && !dec_i) begin
            res_o = (val_i == MAX) ? '0 : val_i + W'(1);
        end else if (dec_i && !inc_i) begin
            res_o = (val_i == '0) ? MAX : val_i - W'(1);
        end
    end

endmodule

// File: rtl/scoot_world.sv
// Grid-world stage: token bitmap, robot position on a torus, pickup and step accounting.
module scoot_world
    import scoot_pkg::*;
#(
    parameter int              WIDTH     = DEF_WIDTH,
    parameter int              HEIGHT    = DEF_HEIGHT,
    parameter int              NUM_STEPS = DEF_NUM_STEPS,
    parameter logic [HEIGHT-1:0] INIT_COL = HEIGHT'(10'b0010101001)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 step_en,
    scoot_world_if.slave                         robot,
    output logic [$clog2(WIDTH)-1:0]             pos_x,
    output logic [$clog2(HEIGHT)-1:0]            pos_y,
    output logic [$clog2(NUM_STEPS+1)-1:0]       step_count,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pickup_count,
    output logic                                 pickup,
    output logic                                 done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SW = $clog2(NUM_STEPS + 1);
    localparam int PW = $clog2(WIDTH * HEIGHT + 1);

    state_e            state_q, state_d;
    logic [XW-1:0]     pos_x_q, pos_x_d;
    logic [YW-1:0]     pos_y_q, pos_y_d;
    logic [SW-1:0]     step_count_q, step_count_d;
    logic [PW-1:0]     pickup_count_q, pickup_count_d;
    logic              pickup_q, pickup_d;
    logic [HEIGHT-1:0] grid_q [WIDTH];
    logic [HEIGHT-1:0] grid_d [WIDTH];

    logic [3:0]    motors;
    logic [XW-1:0] x_move, x_plus, x_minus;
    logic [YW-1:0] y_move, y_plus, y_minus;

    assign motors[UP]    = robot.mUp;
    assign motors[RIGHT] = robot.mRight;
    assign motors[DOWN]  = robot.mDown;
    assign motors[LEFT]  = robot.mLeft;

    scoot_wrap_step #(.N(WIDTH))  u_x_move  (.val_i(pos_x_q), .inc_i(motors[RIGHT]), .dec_i(motors[LEFT]), .res_o(x_move));
    scoot_wrap_step #(.N(HEIGHT)) u_y_move  (.val_i(pos_y_q), .inc_i(motors[UP]),    .dec_i(motors[DOWN]), .res_o(y_move));
    scoot_wrap_step #(.N(WIDTH))  u_x_plus  (.val_i(pos_x_q), .inc_i(1'b1), .dec_i(1'b0), .res_o(x_plus));
    scoot_wrap_step #(.N(WIDTH))  u_x_minus (.val_i(pos_x_q), .inc_i(1'b0), .dec_i(1'b1), .res_o(x_minus));
    scoot_wrap_step #(.N(HEIGHT)) u_y_plus  (.val_i(pos_y_q), .inc_i(1'b1), .dec_i(1'b0), .res_o(y_plus));
    scoot_wrap_step #(.N(HEIGHT)) u_y_minus (.val_i(pos_y_q), .inc_i(1'b0), .dec_i(1'b1), .res_o(y_minus));

    assign robot.lUp    = grid_q[pos_x_q][y_plus];
    assign robot.lDown  = grid_q[pos_x_q][y_minus];
    assign robot.lRight = grid_q[x_plus][pos_y_q];
    assign robot.lLeft  = grid_q[x_minus][pos_y_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pos_x_q        <= XW'(WIDTH / 2);
            pos_y_q        <= YW'(HEIGHT / 2);
            step_count_q   <= '0;
            pickup_count_q <= '0;
            pickup_q       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                grid_q[i] <= INIT_COL;
            end
        end else begin
            state_q        <= state_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            step_count_q   <= step_count_d;
            pickup_count_q <= pickup_count_d;
            pickup_q       <= pickup_d;
            grid_q         <= grid_d;
        end
    end

    // Pickup is judged at the pre-move position; the move lands on the same edge
    always_comb begin
        state_d        = state_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        step_count_d   = step_count_q;
        pickup_count_d = pickup_count_q;
        pickup_d       = 1'b0;
        grid_d         = grid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step_en) begin
                    if (grid_q[pos_x_q][pos_y_q]) begin
                        grid_d[pos_x_q][pos_y_q] = 1'b0;
                        pickup_d                 = 1'b1;
                        pickup_count_d           = pickup_count_q + PW'(1);
                    end
                    pos_x_d      = x_move;
                    pos_y_d      = y_move;
                    step_count_d = step_count_q + SW'(1);
                    if (step_count_q == SW'(NUM_STEPS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Re-arm keeps the grid as the previous run left it
                if (start) begin
                    state_d        = IDLE;
                    pos_x_d        = XW'(WIDTH / 2);
                    pos_y_d        = YW'(HEIGHT / 2);
                    step_count_d   = '0;
                    pickup_count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign step_count   = step_count_q;
    assign pickup_count = pickup_count_q;
    assign pickup       = pickup_q;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_scoot_world.sv
// Directed bench for scoot_world: a 100-step instance driven through the main scenarios and a 4-step instance for run completion.
module tb_scoot_world;
    import scoot_pkg::*;

    localparam logic [3:0] M_NONE  = 4'b0000;
    localparam logic [3:0] M_UP    = 4'b0001;
    localparam logic [3:0] M_RIGHT = 4'b0010;
    localparam logic [3:0] M_DOWN  = 4'b0100;
    localparam logic [3:0] M_LEFT  = 4'b1000;
    localparam logic [3:0] M_ALL   = 4'b1111;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, stepEn, start4, stepEn4;
    logic [3:0] posX, posY, posX4, posY4;
    logic [6:0] stepCount, pickupCount, pickupCount4;
    logic [2:0] stepCount4;
    logic       pickup, done, pickup4, done4;

    int checks = 0;
    int errors = 0;
    int expQ[$];

    scoot_world_if robotIf ();
    scoot_world_if robotIf4 ();

    scoot_world dut (
        .clock(clock), .reset_n(reset_n), .start(start), .step_en(stepEn),
        .robot(robotIf.slave), .pos_x(posX), .pos_y(posY), .step_count(stepCount),
        .pickup_count(pickupCount), .pickup(pickup), .done(done)
    );

    scoot_world #(.NUM_STEPS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .step_en(stepEn4),
        .robot(robotIf4.slave), .pos_x(posX4), .pos_y(posY4), .step_count(stepCount4),
        .pickup_count(pickupCount4), .pickup(pickup4), .done(done4)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; a non-negative expPick is the pickup_count the monitor should see
    task automatic applyStimulus(input bit sel4, input bit s, input bit e, input logic [3:0] m, input int expPick);
        if (expPick >= 0) expQ.push_back(expPick);
        if (!sel4) begin
            start = s; stepEn = e;
            robotIf.mUp = m[UP]; robotIf.mRight = m[RIGHT];
            robotIf.mDown = m[DOWN]; robotIf.mLeft = m[LEFT];
        end else begin
            start4 = s; stepEn4 = e;
            robotIf4.mUp = m[UP]; robotIf4.mRight = m[RIGHT];
            robotIf4.mDown = m[DOWN]; robotIf4.mLeft = m[LEFT];
        end
        @(posedge clock);
        #1;
        start = 1'b0; stepEn = 1'b0; start4 = 1'b0; stepEn4 = 1'b0;
        robotIf.mUp = 1'b0; robotIf.mRight = 1'b0; robotIf.mDown = 1'b0; robotIf.mLeft = 1'b0;
        robotIf4.mUp = 1'b0; robotIf4.mRight = 1'b0; robotIf4.mDown = 1'b0; robotIf4.mLeft = 1'b0;
    endtask

    // Scoreboard monitor: every pickup pulse must match the next queued expectation
    always @(negedge clock) begin
        if (reset_n && pickup) begin
            int e;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPickup: pickup_count=%0d, no pickup expected", pickupCount);
            end else begin
                e = expQ.pop_front();
                if (int'(pickupCount) != e) begin
                    errors++;
                    $display("[TB] FAIL pickupScoreboard: pickup_count=%0d, expected %0d", pickupCount, e);
                end
            end
        end
    end

    initial begin
        int downExp[5] = '{-1, -1, 7, -1, -1};
        reset_n = 1'b0;
        start = 1'b0; stepEn = 1'b0; start4 = 1'b0; stepEn4 = 1'b0;
        robotIf.mUp = 1'b0; robotIf.mRight = 1'b0; robotIf.mDown = 1'b0; robotIf.mLeft = 1'b0;
        robotIf4.mUp = 1'b0; robotIf4.mRight = 1'b0; robotIf4.mDown = 1'b0; robotIf4.mLeft = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("resetPosX", int'(posX), 5);
        checkOutput("resetPosY", int'(posY), 5);
        checkOutput("resetLUp", int'(robotIf.lUp), 0);
        checkOutput("resetLDown", int'(robotIf.lDown), 0);
        checkOutput("resetLRight", int'(robotIf.lRight), 1);
        checkOutput("resetLLeft", int'(robotIf.lLeft), 1);
        checkOutput("resetSteps", int'(stepCount), 0);
        checkOutput("resetPickups", int'(pickupCount), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetPickup", int'(pickup), 0);

        $display("[TB] first step right with pickup");
        applyStimulus(0, 1, 0, M_NONE, -1);
        applyStimulus(0, 0, 1, M_RIGHT, 1);
        checkOutput("step1PosX", int'(posX), 6);
        checkOutput("step1PosY", int'(posY), 5);
        checkOutput("step1Pickup", int'(pickup), 1);
        checkOutput("step1Pickups", int'(pickupCount), 1);
        checkOutput("step1Steps", int'(stepCount), 1);
        checkOutput("step1LLeftCleared", int'(robotIf.lLeft), 0);
        checkOutput("step1LRight", int'(robotIf.lRight), 1);

        $display("[TB] wrap in x");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, M_RIGHT, 2 + i);
        checkOutput("wrapRightPosX", int'(posX), 0);
        checkOutput("wrapRightPickups", int'(pickupCount), 5);
        applyStimulus(0, 0, 1, M_LEFT, 6);
        checkOutput("wrapLeftPosX", int'(posX), 9);

        $display("[TB] wrap in y");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, M_DOWN, downExp[i]);
        checkOutput("downPosY", int'(posY), 0);
        checkOutput("downPosX", int'(posX), 9);
        applyStimulus(0, 0, 1, M_DOWN, 8);
        checkOutput("wrapDownPosY", int'(posY), 9);
        checkOutput("wrapDownPickups", int'(pickupCount), 8);

        $display("[TB] cancelling and diagonal motors");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, M_ALL, -1);
        checkOutput("cancelPosX", int'(posX), 9);
        checkOutput("cancelPosY", int'(posY), 9);
        checkOutput("cancelSteps", int'(stepCount), 15);
        applyStimulus(0, 0, 1, M_UP | M_RIGHT, -1);
        checkOutput("diagPosX", int'(posX), 0);
        checkOutput("diagPosY", int'(posY), 0);
        applyStimulus(0, 0, 1, M_LEFT | M_DOWN, 9);
        checkOutput("diag2PosX", int'(posX), 9);
        checkOutput("diag2PosY", int'(posY), 9);
        checkOutput("diag2Steps", int'(stepCount), 17);

        $display("[TB] ignored start and motors without step_en");
        applyStimulus(0, 1, 0, M_UP, -1);
        applyStimulus(0, 0, 0, M_UP, -1);
        checkOutput("idleStepsHold", int'(stepCount), 17);
        checkOutput("idlePosYHold", int'(posY), 9);
        checkOutput("runNotDone", int'(done), 0);

        $display("[TB] four-step run");
        applyStimulus(1, 1, 0, M_NONE, -1);
        applyStimulus(1, 0, 1, M_UP, -1);
        checkOutput("run4Pickup", int'(pickup4), 1);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, M_UP, -1);
        checkOutput("run4NotDone", int'(done4), 0);
        applyStimulus(1, 0, 1, M_UP, -1);
        checkOutput("run4Done", int'(done4), 1);
        checkOutput("run4Steps", int'(stepCount4), 4);
        checkOutput("run4PosY", int'(posY4), 9);
        checkOutput("run4Pickups", int'(pickupCount4), 2);
        applyStimulus(1, 0, 1, M_UP, -1);
        checkOutput("run4FrozenPosY", int'(posY4), 9);
        checkOutput("run4FrozenSteps", int'(stepCount4), 4);
        applyStimulus(1, 1, 0, M_NONE, -1);
        checkOutput("rearmDone", int'(done4), 0);
        checkOutput("rearmSteps", int'(stepCount4), 0);
        checkOutput("rearmPickups", int'(pickupCount4), 0);
        checkOutput("rearmPosX", int'(posX4), 5);
        checkOutput("rearmPosY", int'(posY4), 5);
        checkOutput("rearmLUp", int'(robotIf4.lUp), 0);
        checkOutput("rearmLDown", int'(robotIf4.lDown), 0);
        checkOutput("rearmLRight", int'(robotIf4.lRight), 1);
        checkOutput("rearmLLeft", int'(robotIf4.lLeft), 1);
        applyStimulus(1, 1, 0, M_NONE, -1);
        applyStimulus(1, 0, 1, M_UP, -1);
        checkOutput("rearmNoReload", int'(pickupCount4), 0);
        checkOutput("rearmStepPosY", int'(posY4), 6);

        $display("[TB] asynchronous reset mid-run");
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("asyncPosX", int'(posX), 5);
        checkOutput("asyncPosY", int'(posY), 5);
        checkOutput("asyncSteps", int'(stepCount), 0);
        checkOutput("asyncPickups", int'(pickupCount), 0);
        checkOutput("asyncReloadRight", int'(robotIf.lRight), 1);
        checkOutput("asyncSteps4", int'(stepCount4), 0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(0, 0, 1, M_RIGHT, -1);
        checkOutput("idleIgnoresStep", int'(posX), 5);
        applyStimulus(0, 1, 0, M_NONE, -1);
        applyStimulus(0, 0, 1, M_UP, 1);
        checkOutput("reloadPosY", int'(posY), 6);
        checkOutput("reloadPickups", int'(pickupCount), 1);
        checkOutput("reloadLDown", int'(robotIf.lDown), 0);

        repeat (3) @(negedge clock);
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
